// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-and-add multiplier:
// controller state encoding and the default operand width.
package mul_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/barrel_shift_left.sv
// Combinational left-only barrel shifter, zero-fill, built from log2
// mux stages; each stage shifts by a power of two selected by one shamt bit.
module barrel_shift_left #(
    parameter int DW  = 16,
    parameter int SHW = 3
) (
    input  logic [DW-1:0]  data_i,
    input  logic [SHW-1:0] shamt_i,
    output logic [DW-1:0]  data_o
);

    logic [DW-1:0] stage [0:SHW];

    assign stage[0] = data_i;

    for (genvar s = 0; s < SHW; s++) begin : g_stage
        assign stage[s+1] = shamt_i[s] ? (stage[s] << (1 << s)) : stage[s];
    end

    assign data_o = stage[SHW];

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned WIDTH x WIDTH multiplier: one shifted partial product
// is conditionally accumulated per cycle, with valid/ready on both sides.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int SHW = $clog2(WIDTH);

    state_e               state_q, state_d;
    logic [SHW-1:0]       step_q, step_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   partial;

    barrel_shift_left #(
        .DW  (2*WIDTH),
        .SHW (SHW)
    ) u_shl (
        .data_i  ({{WIDTH{1'b0}}, a_q}),
        .shamt_i (step_q),
        .data_o  (partial)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (b_q[step_q]) acc_d = acc_q + partial;
                // step is exactly log2(WIDTH) bits, so it wraps to 0 on the last step
                step_d = step_q + SHW'(1);
                if (step_q == SHW'(WIDTH - 1)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = acc_q;

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Iterative unsigned WIDTH x WIDTH multiplier; one partial product per cycle.
- Consumes the left-shift function of the team's barrel shifter: each step adds multiplicand << k, with k the step index, into a 2*WIDTH accumulator.
- Sits downstream of the shifter in the datapath.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 8, operand width in bits; must be a power of 2 and at least 2.
- SHW, $clog2(WIDTH) (3 at default), shift-amount width; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; asserting clears all state immediately; release is synchronous to clk.
- in_valid  input  1  operand pair a/b is valid.
- in_ready  output  1  block accepts operands; high only in IDLE.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  a*b, unsigned, full width, never truncated.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, step=0, acc=0, a_q=0, b_q=0; outputs in_ready=1, out_valid=0, product=0.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a_q=a, b_q=b, clear acc=0 and step=0, go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each edge: if b_q[step]=1 then acc <= acc + ({WIDTH'b0,a_q} << step), else acc is held.
  - Shift is left, zero-fill, 2*WIDTH bits wide, shamt=step.
  - step increments each edge.
  - On the edge where step==WIDTH-1: go to DONE; step wraps to 0.
- DONE:
  - out_valid=1; product=acc, held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: go to IDLE.
  - in_valid is ignored in DONE; no accept in the same cycle as the handoff.
- Latency: acceptance edge E; out_valid rises after edge E+WIDTH (8 at default).
  - Throughput: one result per WIDTH+2 cycles with out_ready held at 1.
- Arithmetic:
  - acc is 2*WIDTH bits; no overflow is possible since the maximum is (2^W-1)^2.
  - Addition is plain unsigned; no carry-out is kept.
- Boundary conditions:
  - in_valid during BUSY or DONE: ignored; a and b are not sampled; no state change.
  - b=0 or a=0: all BUSY steps add nothing; product=0 with the normal latency.
  - Latency is fixed regardless of b's bit pattern; there is no early termination.
  - out_ready already high when DONE is entered: out_valid is high for exactly one cycle.
  - rst_n asserted mid-BUSY or mid-DONE: abort immediately to the reset values; the partial result is discarded. After release, the block waits in IDLE.
  - a and b may change freely after acceptance; only a_q and b_q are used.
- State encoding: 2-bit; IDLE=0, BUSY=1, DONE=2. Code 3 is illegal and returns to IDLE on the next edge.

Decomposition:
- Shared package mul_pkg:
  - state typedef (IDLE, BUSY, DONE) with its encodings.
  - Default WIDTH constant.
- One sub-module: barrel_shift_left.
  - Combinational, 2*WIDTH data, SHW-bit shamt, logarithmic mux stages, zero-fill.
  - Left-only, 2*WIDTH-wide member of the team's barrel shifter family.
  - Instantiated once; fed {0,a_q} and step; its output is gated by b_q[step].
- The FSM, counter and accumulator live in the top module.

Test Plan:
- Reset hold, then a=8'h66, b=8'h03, in_valid pulse, out_ready=1 -> out_valid rises exactly 8 cycles after the accept edge; product=16'h0132; returns to IDLE.
- a=8'hFF, b=8'hFF -> product=16'hFE01. Also a=8'h76, b=8'h05 -> product=16'h024E.
- a=8'h00, b=8'hB7 and a=8'h5A, b=8'h00 -> product=16'h0000 for each, with latency still 8.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> product and out_valid stable; in_ready=0 throughout; new in_valid with a=8'h11 is not accepted; release out_ready -> IDLE.
- in_valid with a=8'h22, b=8'h02 held high during BUSY -> ignored; the first result is unaffected.
- rst_n=0 pulsed at BUSY step 4 (a=8'h0F, b=8'hFF) -> out_valid=0 and product=0 immediately, with no clock edge needed. Then a=8'h0F, b=8'h02 -> product=16'h001E.
